// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the 16 x 32 general-purpose register file.
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_bank_cell.sv
// One storage word of the register file: async active-low clear, load on write enable.
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_bank_16x32.sv
// Register file with two combinational read ports and one clocked write port.
// Reads have no bypass: a write becomes visible only after the capturing edge.
module register_bank_16x32
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] WC,
    input  logic [DATA_W-1:0] WPC,
    input  logic              W_RB,
    output logic [DATA_W-1:0] PRA,
    output logic [DATA_W-1:0] PRB
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  write_sel;
    logic [DATA_W-1:0] regs [DEPTH];

    // One-hot write select; all-zero when the write enable is low.
    always_comb begin
        write_sel = '0;
        if (W_RB) begin
            write_sel[WC] = 1'b1;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        reg_bank_cell #(
            .W (DATA_W)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (write_sel[i]),
            .d     (WPC),
            .q     (regs[i])
        );
    end

    always_comb begin
        PRA = regs[RA];
        PRB = regs[RB];
    end

endmodule

// File: tb/tb_register_bank_16x32.sv
// Randomized self-checking bench for register_bank_16x32 against an array model.
module tb_register_bank_16x32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  RA    = '0;
    logic [3:0]  RB    = '0;
    logic [3:0]  WC    = '0;
    logic [31:0] WPC   = '0;
    logic        W_RB  = 1'b0;
    logic [31:0] PRA;
    logic [31:0] PRB;

    logic [31:0] model [16];
    int          tests    = 0;
    int          failures = 0;
    bit          check_en = 1'b0;

    register_bank_16x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RA    (RA),
        .RB    (RB),
        .WC    (WC),
        .WPC   (WPC),
        .W_RB  (W_RB),
        .PRA   (PRA),
        .PRB   (PRB)
    );

    always #5 clk = ~clk;

    // Reference model: an array of words, cleared whenever reset is low.
    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 16; i++) model[i] = '0;
    end

    always @(posedge clk) begin
        if (rst_n && W_RB) model[WC] = WPC;
    end

    // Continuous check on the falling edge, away from input changes and writes.
    always @(negedge clk) begin
        if (check_en) begin
            tests++;
            if (PRA !== model[RA] || PRB !== model[RB]) begin
                failures++;
                $display("[TB] FAIL model_cmp RA=%0d RB=%0d: PRA=%h PRB=%h expected PRA=%h PRB=%h",
                         RA, RB, PRA, PRB, model[RA], model[RB]);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] exp_a,
                                input logic [31:0] exp_b);
        tests++;
        if (PRA !== exp_a || PRB !== exp_b) begin
            failures++;
            $display("[TB] FAIL %s: PRA=%h PRB=%h expected PRA=%h PRB=%h",
                     name, PRA, PRB, exp_a, exp_b);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_write(input logic [3:0] addr, input logic [31:0] data);
        WC   = addr;
        WPC  = data;
        W_RB = 1'b1;
        next_cycle();
        W_RB = 1'b0;
    endtask

    initial begin
        logic [31:0] data;

        // Reset sweep: every address reads zero while reset is held.
        #1 rst_n = 1'b0;
        #1 check_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            RA = 4'(i);
            RB = 4'(15 - i);
            #1 check_output("reset_sweep", 32'h0, 32'h0);
        end
        WC = 4'd4; WPC = 32'hFFFF_FFFF; W_RB = 1'b1;
        next_cycle();
        W_RB = 1'b0;
        RA = 4'd4;
        #1 check_output("write_in_reset", 32'h0, 32'h0);
        rst_n = 1'b1;

        // Fill reg[i] = i, then read adjacent pairs.
        next_cycle();
        for (int i = 0; i < 16; i++) apply_write(4'(i), 32'(i));
        for (int i = 0; i < 16; i += 2) begin
            RA = 4'(i);
            RB = 4'(i + 1);
            #1 check_output("fill_pair", 32'(i), 32'(i + 1));
        end

        // Random data with one known word.
        for (int i = 0; i < 16; i++) begin
            data = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            apply_write(4'(i), data);
        end
        for (int i = 0; i < 15; i++) begin
            RA = 4'(i);
            RB = 4'(i + 1);
            #1 check_output("random_pair", model[i], model[i + 1]);
        end
        RA = 4'd5; RB = 4'd5;
        #1 check_output("reg5_literal", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Write disable holds the stored value.
        apply_write(4'd7, 32'h1234_5678);
        WC = 4'd7; WPC = 32'hFFFF_FFFF; W_RB = 1'b0; RA = 4'd7;
        repeat (3) next_cycle();
        check_output("write_disable", 32'h1234_5678, model[RB]);

        // Read-during-write: old value before the edge, new after it.
        apply_write(4'd3, 32'hA);
        RA = 4'd3; RB = 4'd3; WC = 4'd3; WPC = 32'hB; W_RB = 1'b1;
        #1 check_output("rdw_before", 32'hA, 32'hA);
        @(posedge clk);
        #1 check_output("rdw_after", 32'hB, 32'hB);
        #1 W_RB = 1'b0;

        // Randomized mixed traffic.
        for (int n = 0; n < 200; n++) begin
            WC   = 4'($urandom_range(0, 15));
            WPC  = $urandom;
            W_RB = 1'($urandom_range(0, 1));
            RA   = 4'($urandom_range(0, 15));
            RB   = 4'($urandom_range(0, 15));
            next_cycle();
        end
        W_RB = 1'b0;

        // Async reset between edges with nonzero contents.
        for (int i = 0; i < 16; i++) apply_write(4'(i), $urandom | 32'h1);
        RA = 4'd5; RB = 4'd9;
        #1 check_output("pre_async_reset", model[5], model[9]);
        rst_n = 1'b0;
        #1 check_output("async_reset", 32'h0, 32'h0);
        #1 rst_n = 1'b1;
        apply_write(4'd15, 32'h1);
        RA = 4'd15; RB = 4'd0;
        #1 check_output("post_reset_write", 32'h1, 32'h0);

        next_cycle();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
